dmem_arbiter: RTL and testbench

- Shares the single-port data memory between the CPU MEM stage and a DMA/debug requester.
- CPU has fixed priority, so the pipeline normally sees zero added latency.
- A starvation counter forces a bounded DMA burst slot, during which the CPU pipeline is stalled.
- Sits between the MEM-stage pipeline register outputs and the data_memory instance.

---
 rtl/dmem_arbiter_pkg.sv | 33 +++
 rtl/dmem_arb_fsm.sv | 110 +++++++++++
 rtl/dmem_arbiter.sv | 125 ++++++++++++
 tb/tb_dmem_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_pkg
// Description : Shared encodings for the data-memory arbiter.
//               Holds the arbiter state codes, the memory owner-select codes,
//               and a width helper used to size the internal counters.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;

    // Arbiter states: S_CPU is normal operation (CPU has fixed priority),
    // S_DMA is the forced DMA slot that relieves a starved requester.
    localparam logic [0:0] S_CPU = 1'b0;
    localparam logic [0:0] S_DMA = 1'b1;

    // Memory owner select: which requester drives the data_memory port.
    localparam logic [0:0] OWN_CPU = 1'b0;
    localparam logic [0:0] OWN_DMA = 1'b1;

    // Number of bits needed to hold the values 0..max_val, never below 1.
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) <= max_val) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arb_fsm.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_fsm
// Description : Grant controller for the data-memory arbiter.
//               Tracks how long the DMA requester has been refused and forces
//               a bounded DMA slot once that wait reaches STARVE_LIMIT.
// Ports       : clk, rst (async, active-low)
//               cpu_req, dma_valid, dma_last   - request inputs
//               owner      - OWN_CPU / OWN_DMA memory select
//               dma_ready  - DMA beat accepted this cycle
//               cpu_stall  - hold the CPU pipeline this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arb_fsm
    import dmem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 3,
    parameter int MAX_BURST    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_req,
    input  logic       dma_valid,
    input  logic       dma_last,
    output logic [0:0] owner,
    output logic       dma_ready,
    output logic       cpu_stall
);

    localparam int c_SW = cnt_width(STARVE_LIMIT);
    localparam int c_BW = cnt_width(MAX_BURST - 1);
    localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(STARVE_LIMIT);
    localparam logic [c_BW-1:0] c_BEAT_LAST  = c_BW'(MAX_BURST - 1);

    logic [0:0]      r_state;
    logic [c_SW-1:0] r_starve_cnt;
    logic [c_BW-1:0] r_beat_cnt;

    logic [0:0]      w_owner;
    logic            w_dma_ready;
    logic            w_cpu_stall;

    // Grant decode. These must be combinational: the CPU pipeline and the
    // DMA handshake both need the decision in the same cycle as the request.
    // While reset is asserted nothing is granted and nothing is stalled.
    always_comb begin
        w_owner     = OWN_CPU;
        w_dma_ready = 1'b0;
        w_cpu_stall = 1'b0;
        if (rst) begin
            if (r_state == S_DMA) begin
                // Forced slot: DMA beats win; a DMA bubble hands the cycle
                // back to the CPU without a stall.
                if (dma_valid) begin
                    w_owner     = OWN_DMA;
                    w_dma_ready = 1'b1;
                    w_cpu_stall = cpu_req;
                end
            end else if (!cpu_req && dma_valid) begin
                // CPU idle: DMA gets the port opportunistically.
                w_owner     = OWN_DMA;
                w_dma_ready = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_CPU;
            r_starve_cnt <= '0;
            r_beat_cnt   <= '0;
        end else if (r_state == S_CPU) begin
            r_beat_cnt <= '0;
            if (!dma_valid || w_dma_ready) begin
                // Either nothing is waiting or the beat just went through.
                r_starve_cnt <= '0;
            end else if (r_starve_cnt == c_STARVE_MAX) begin
                // Refused again with the counter already at its limit: the
                // next cycle becomes a forced DMA slot. A beat that was
                // accepted opportunistically at the limit already relieved
                // the wait, so it takes the clearing branch above instead.
                r_state      <= S_DMA;
                r_starve_cnt <= '0;
            end else begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end else begin
            // Every S_DMA cycle either accepts a beat or ends the slot, and
            // both clear the starvation count.
            r_starve_cnt <= '0;
            if (dma_valid) begin
                if (dma_last || (r_beat_cnt == c_BEAT_LAST)) begin
                    r_state    <= S_CPU;
                    r_beat_cnt <= '0;
                end else begin
                    r_beat_cnt <= r_beat_cnt + 1'b1;
                end
            end else begin
                r_state    <= S_CPU;
                r_beat_cnt <= '0;
            end
        end
    end

    assign owner     = w_owner;
    assign dma_ready = w_dma_ready;
    assign cpu_stall = w_cpu_stall;

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares the single-port data memory between the CPU MEM stage
//               (fixed priority, zero added latency) and a DMA/debug port.
//               A starvation counter forces bounded DMA slots during which
//               the CPU pipeline is stalled.
// Ports       : clk, rst (async, active-low)
//               cpu_*  - MEM-stage request, store data, load data, stall
//               dma_*  - valid/ready beat interface, registered read return
//               mem_*  - connection to the data_memory instance
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DSIZE        = 16,
    parameter int STARVE_LIMIT = 3,
    parameter int MAX_BURST    = 4
) (
    input  logic             clk,
    input  logic             rst,
    // CPU MEM stage
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [DSIZE-1:0] cpu_addr,
    input  logic [DSIZE-1:0] cpu_wdata,
    output logic [DSIZE-1:0] cpu_rdata,
    output logic             cpu_stall,
    // DMA / debug requester
    input  logic             dma_valid,
    input  logic             dma_last,
    input  logic             dma_we,
    input  logic [DSIZE-1:0] dma_addr,
    input  logic [DSIZE-1:0] dma_wdata,
    output logic             dma_ready,
    output logic [DSIZE-1:0] dma_rdata,
    output logic             dma_rvalid,
    // data_memory
    output logic             mem_wen,
    output logic             mem_ren,
    output logic [DSIZE-1:0] mem_addr,
    output logic [DSIZE-1:0] mem_wdata,
    input  logic [DSIZE-1:0] mem_rdata
);

    logic [0:0]       w_owner;
    logic             w_dma_ready;
    logic             w_cpu_stall;
    logic             w_mem_wen;
    logic             w_mem_ren;
    logic [DSIZE-1:0] w_mem_addr;
    logic [DSIZE-1:0] w_mem_wdata;
    logic             w_dma_rd_accept;

    logic [DSIZE-1:0] r_dma_rdata;
    logic             r_dma_rvalid;

    dmem_arb_fsm #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .MAX_BURST    (MAX_BURST)
    ) u_fsm (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .dma_valid (dma_valid),
        .dma_last  (dma_last),
        .owner     (w_owner),
        .dma_ready (w_dma_ready),
        .cpu_stall (w_cpu_stall)
    );

    // Memory-side mux. The owner's write-enable picks write vs read; the
    // non-owner's address and data never reach the memory. Everything is
    // held at zero while reset is asserted.
    always_comb begin
        w_mem_wen   = 1'b0;
        w_mem_ren   = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        if (rst) begin
            if (w_owner == OWN_DMA) begin
                w_mem_wen   = dma_we;
                w_mem_ren   = ~dma_we;
                w_mem_addr  = dma_addr;
                w_mem_wdata = dma_wdata;
            end else begin
                // CPU owns the port; with no CPU request both enables stay low.
                w_mem_wen   = cpu_req & cpu_we;
                w_mem_ren   = cpu_req & ~cpu_we;
                w_mem_addr  = cpu_addr;
                w_mem_wdata = cpu_wdata;
            end
        end
    end

    assign w_dma_rd_accept = dma_valid & w_dma_ready & ~dma_we;

    // DMA read return: data captured at the accepting edge, rvalid is a
    // single-cycle pulse per accepted read beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dma_rdata  <= '0;
            r_dma_rvalid <= 1'b0;
        end else begin
            r_dma_rvalid <= w_dma_rd_accept;
            if (w_dma_rd_accept) begin
                r_dma_rdata <= mem_rdata;
            end
        end
    end

    // Load data is a straight pass-through so the CPU sees no added latency.
    assign cpu_rdata  = mem_rdata;
    assign cpu_stall  = w_cpu_stall;
    assign dma_ready  = w_dma_ready;
    assign dma_rdata  = r_dma_rdata;
    assign dma_rvalid = r_dma_rvalid;
    assign mem_wen    = w_mem_wen;
    assign mem_ren    = w_mem_ren;
    assign mem_addr   = w_mem_addr;
    assign mem_wdata  = w_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Scoreboard bench for dmem_arbiter. A behavioural model of the
//               arbitration rules predicts each cycle's grant and memory drive
//               plus every DMA read return; a monitor compares at negedge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int DSIZE        = 16;
    localparam int STARVE_LIMIT = 3;
    localparam int MAX_BURST    = 4;

    logic             clk;
    logic             rst;
    logic             cpu_req, cpu_we;
    logic [DSIZE-1:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic             cpu_stall;
    logic             dma_valid, dma_last, dma_we;
    logic [DSIZE-1:0] dma_addr, dma_wdata;
    logic             dma_ready;
    logic [DSIZE-1:0] dma_rdata;
    logic             dma_rvalid;
    logic             mem_wen, mem_ren;
    logic [DSIZE-1:0] mem_addr, mem_wdata, mem_rdata;

    dmem_arbiter #(
        .DSIZE        (DSIZE),
        .STARVE_LIMIT (STARVE_LIMIT),
        .MAX_BURST    (MAX_BURST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .dma_valid  (dma_valid),
        .dma_last   (dma_last),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_ready  (dma_ready),
        .dma_rdata  (dma_rdata),
        .dma_rvalid (dma_rvalid),
        .mem_wen    (mem_wen),
        .mem_ren    (mem_ren),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment memory (combinational read, written on the clock edge).
    logic [DSIZE-1:0] tb_mem  [0:255];
    // Model's own view of memory contents, updated from predicted writes.
    logic [DSIZE-1:0] ref_mem [0:255];
    assign mem_rdata = tb_mem[mem_addr[7:0]];

    typedef struct {
        logic             stall;
        logic             ready;
        logic             wen;
        logic             ren;
        logic             cpu_rd;
        logic [DSIZE-1:0] addr;
        logic [DSIZE-1:0] wdata;
        logic [DSIZE-1:0] rdata;
    } exp_t;

    typedef struct {
        int               due;
        logic [DSIZE-1:0] data;
    } rd_t;

    exp_t q_comb[$];
    rd_t  q_rd[$];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model state: refused cycles in the current wait, whether a
    // forced slot is running, and beats served in that slot.
    int m_waited     = 0;
    bit m_in_slot    = 1'b0;
    int m_slot_beats = 0;
    bit m_acc        = 1'b0;

    // One clock cycle: predict, queue expectations, let the edge happen,
    // then advance the model. Called at posedge+1 with inputs already set.
    task automatic step();
        exp_t             e;
        rd_t              r;
        logic             own_dma;
        logic             dut_wen;
        logic [DSIZE-1:0] dut_addr, dut_wdata;
        if (!rst) begin
            m_in_slot    = 1'b0;
            m_slot_beats = 0;
            m_waited     = 0;
            q_rd.delete();
        end
        e = '{default: '0};
        own_dma = 1'b0;
        if (rst) begin
            own_dma = m_in_slot ? dma_valid : (!cpu_req && dma_valid);
            e.ready = own_dma;
            e.stall = m_in_slot && dma_valid && cpu_req;
            if (own_dma) begin
                e.wen   = dma_we;
                e.ren   = !dma_we;
                e.addr  = dma_addr;
                e.wdata = dma_wdata;
            end else if (cpu_req) begin
                e.wen    = cpu_we;
                e.ren    = !cpu_we;
                e.addr   = cpu_addr;
                e.wdata  = cpu_wdata;
                e.cpu_rd = !cpu_we;
                e.rdata  = ref_mem[cpu_addr[7:0]];
            end
        end
        m_acc = own_dma;
        q_comb.push_back(e);
        if (own_dma && !dma_we) begin
            r.due  = cyc + 1;
            r.data = ref_mem[dma_addr[7:0]];
            q_rd.push_back(r);
        end
        @(negedge clk);
        dut_wen   = mem_wen;
        dut_addr  = mem_addr;
        dut_wdata = mem_wdata;
        @(posedge clk);
        if (dut_wen) tb_mem[dut_addr[7:0]] = dut_wdata;
        if (e.wen)   ref_mem[e.addr[7:0]]  = e.wdata;
        if (rst) begin
            if (m_in_slot) begin
                if (dma_valid) begin
                    m_slot_beats++;
                    if (dma_last || m_slot_beats >= MAX_BURST) begin
                        m_in_slot    = 1'b0;
                        m_slot_beats = 0;
                    end
                end else begin
                    m_in_slot    = 1'b0;
                    m_slot_beats = 0;
                end
                m_waited = 0;
            end else if (dma_valid && !own_dma) begin
                m_waited++;
                if (m_waited > STARVE_LIMIT) begin
                    m_in_slot = 1'b1;
                    m_waited  = 0;
                end
            end else begin
                m_waited = 0;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        cpu_req   = 1'b0;
        dma_valid = 1'b0;
        dma_last  = 1'b0;
        repeat (n) step();
    endtask

    // Monitor: compares DUT outputs mid-cycle against the queued predictions.
    initial begin
        exp_t e;
        rd_t  r;
        int   stall_run;
        int   wait_run;
        stall_run = 0;
        wait_run  = 0;
        forever begin
            @(negedge clk);
            if (q_comb.size() > 0) begin
                e = q_comb.pop_front();
                tests++;
                if (cpu_stall !== e.stall || dma_ready !== e.ready ||
                    mem_wen !== e.wen || mem_ren !== e.ren ||
                    ((e.wen || e.ren) && mem_addr !== e.addr) ||
                    (e.wen && mem_wdata !== e.wdata) ||
                    (e.cpu_rd && cpu_rdata !== e.rdata)) begin
                    fails++;
                    $display("FAIL grant cyc=%0d got stall=%b ready=%b wen=%b ren=%b addr=%h wd=%h crd=%h want stall=%b ready=%b wen=%b ren=%b addr=%h wd=%h crd=%h",
                             cyc, cpu_stall, dma_ready, mem_wen, mem_ren, mem_addr, mem_wdata, cpu_rdata,
                             e.stall, e.ready, e.wen, e.ren, e.addr, e.wdata, e.rdata);
                end
            end
            if (!rst) begin
                tests++;
                if (dma_rvalid !== 1'b0 || dma_rdata !== '0) begin
                    fails++;
                    $display("FAIL reset_regs cyc=%0d got rvalid=%b rdata=%h want 0 0000",
                             cyc, dma_rvalid, dma_rdata);
                end
            end else if (dma_rvalid) begin
                tests++;
                if (q_rd.size() == 0 || q_rd[0].due != cyc) begin
                    fails++;
                    $display("FAIL rvalid_unexpected cyc=%0d got rvalid=1 rdata=%h want no pulse",
                             cyc, dma_rdata);
                end else begin
                    r = q_rd.pop_front();
                    if (dma_rdata !== r.data) begin
                        fails++;
                        $display("FAIL dma_rdata cyc=%0d got %h want %h", cyc, dma_rdata, r.data);
                    end
                end
            end else if (q_rd.size() > 0 && q_rd[0].due == cyc) begin
                tests++;
                fails++;
                r = q_rd.pop_front();
                $display("FAIL rvalid_missing cyc=%0d got rvalid=0 want 1 data=%h", cyc, r.data);
            end
            // Fairness bounds, independent of the cycle model.
            stall_run = (rst && cpu_stall) ? stall_run + 1 : 0;
            wait_run  = (rst && dma_valid && !dma_ready) ? wait_run + 1 : 0;
            if (stall_run > 0) begin
                tests++;
                if (stall_run > MAX_BURST) begin
                    fails++;
                    $display("FAIL stall_bound cyc=%0d got run=%0d want <=%0d", cyc, stall_run, MAX_BURST);
                end
            end
            if (wait_run > 0) begin
                tests++;
                if (wait_run > STARVE_LIMIT + 1) begin
                    fails++;
                    $display("FAIL dma_wait_bound cyc=%0d got run=%0d want <=%0d", cyc, wait_run, STARVE_LIMIT + 1);
                end
            end
        end
    end

    // Stimulus
    initial begin
        int beat;
        rst       = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        dma_valid = 1'b0;
        dma_last  = 1'b0;
        dma_we    = 1'b0;
        dma_addr  = '0;
        dma_wdata = '0;
        for (int i = 0; i < 256; i++) begin
            tb_mem[i]  = 16'(i * 16'h0101) ^ 16'h5A5A;
            ref_mem[i] = 16'(i * 16'h0101) ^ 16'h5A5A;
        end
        tb_mem[16]  = 16'hBEEF;
        ref_mem[16] = 16'hBEEF;
        @(posedge clk);
        #1;

        // Reset held with both sides requesting.
        cpu_req   = 1'b1;
        dma_valid = 1'b1;
        dma_addr  = 16'h0010;
        repeat (3) step();
        // Release: CPU is granted, DMA refused.
        rst      = 1'b1;
        cpu_addr = 16'h0003;
        step();
        idle(1);

        // Opportunistic DMA read of 0x0010 (holds 0xBEEF).
        dma_valid = 1'b1;
        dma_we    = 1'b0;
        dma_addr  = 16'h0010;
        dma_last  = 1'b1;
        step();
        idle(2);

        // CPU busy, DMA write burst to 0x20..0x27 without dma_last.
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        dma_we   = 1'b1;
        dma_last = 1'b0;
        beat     = 0;
        for (int i = 0; i < 20; i++) begin
            cpu_addr  = 16'($urandom_range(0, 15));
            dma_valid = 1'b1;
            dma_addr  = 16'h0020 + 16'(beat & 7);
            dma_wdata = 16'($urandom);
            step();
            if (m_acc) beat++;
        end
        idle(2);

        // Forced slot ended early by dma_last on beat 2.
        cpu_req = 1'b1;
        dma_we  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            dma_valid = 1'b1;
            dma_last  = m_in_slot && (m_slot_beats == 1);
            dma_addr  = 16'h0040 + 16'(i);
            dma_wdata = 16'($urandom);
            step();
        end
        idle(2);

        // dma_last coinciding with the MAX_BURST-th beat.
        cpu_req = 1'b1;
        dma_we  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            dma_valid = 1'b1;
            dma_last  = m_in_slot && (m_slot_beats == MAX_BURST - 1);
            dma_addr  = 16'h0020 + 16'(i & 7);
            step();
        end
        idle(2);

        // CPU store and DMA read of the same address in the same cycle.
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 16'h0005;
        cpu_wdata = 16'h1234;
        dma_valid = 1'b1;
        dma_we    = 1'b0;
        dma_last  = 1'b1;
        dma_addr  = 16'h0005;
        step();
        cpu_req = 1'b0;
        step();
        idle(2);

        // Reset pulsed during beat 2 of a forced read burst.
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        dma_valid = 1'b1;
        dma_we    = 1'b0;
        dma_last  = 1'b0;
        for (int i = 0; i < 20 && !(m_in_slot && m_slot_beats == 1); i++) begin
            dma_addr = 16'($urandom_range(0, 31));
            step();
        end
        rst = 1'b0;
        step();
        rst = 1'b1;
        repeat (8) step();
        idle(2);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            rst       = ($urandom_range(0, 199) != 0);
            cpu_req   = ($urandom_range(0, 9) < 6);
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = 16'($urandom_range(0, 31));
            cpu_wdata = 16'($urandom);
            dma_valid = ($urandom_range(0, 9) < 7);
            dma_last  = ($urandom_range(0, 3) == 0);
            dma_we    = 1'($urandom_range(0, 1));
            dma_addr  = 16'($urandom_range(0, 31));
            dma_wdata = 16'($urandom);
            step();
        end
        rst = 1'b1;
        idle(3);

        tests++;
        if (q_rd.size() != 0 || q_comb.size() != 0) begin
            fails++;
            $display("FAIL drain got rd=%0d comb=%0d pending want 0 0", q_rd.size(), q_comb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
